// File: rtl/gpu_mem_pkg.sv
// Shared constants and FSM encoding for the GPU RAM host port.
package gpu_mem_pkg;

  localparam int ADDR_W      = 20;
  localparam int DATA_W      = 8;
  localparam int TIMEOUT_DEF = 255;

  localparam logic [DATA_W-1:0] ABORT_DATA = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PEND    = 2'd1,
    ST_RD_WAIT = 2'd2
  } host_state_e;

endpackage

// File: rtl/gpu_rd_return_pipe.sv
// Read-return pipeline: tracks an issued read through the RAM latency and
// captures its data (or the abort pattern) into the host-facing registers.
import gpu_mem_pkg::*;

module gpu_rd_return_pipe #(
  parameter int READ_LATENCY = 2
) (
  input  logic              GPU_CLK,
  input  logic              reset,
  input  logic              rd_launch,
  input  logic              rd_abort,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              rd_done,
  output logic              gpu_rd_rdy,
  output logic [DATA_W-1:0] gpu_rData
);

  logic [READ_LATENCY-1:0] vld_reg;

  // Stage READ_LATENCY-1 marks the cycle in which ram_rdata is valid.
  assign rd_done = vld_reg[READ_LATENCY-1];

  always_ff @(posedge GPU_CLK or negedge reset) begin
    if (!reset) begin
      vld_reg    <= '0;
      gpu_rd_rdy <= 1'b0;
      gpu_rData  <= '0;
    end else begin
      vld_reg    <= READ_LATENCY'({vld_reg, rd_launch});
      gpu_rd_rdy <= rd_done || rd_abort;
      if (rd_done) begin
        gpu_rData <= ram_rdata;
      end else if (rd_abort) begin
        gpu_rData <= ABORT_DATA;
      end
    end
  end

endmodule

// File: rtl/gpu_ram_host_port.sv
// Host-side responder for the shared GPU RAM port: buffers one read and one
// write, issues them on host slots. Optional GPU_HOST_PORT_TIMEOUT_EN abandons stale requests.
import gpu_mem_pkg::*;

module gpu_ram_host_port #(
  parameter int ADDR_W       = gpu_mem_pkg::ADDR_W,
  parameter int READ_LATENCY = 2,
  parameter int TIMEOUT      = TIMEOUT_DEF
) (
  input  logic              GPU_CLK,
  input  logic              reset,
  input  logic [ADDR_W-1:0] gpu_addr,
  input  logic [DATA_W-1:0] gpu_wdata,
  input  logic              gpu_wr_ena,
  input  logic              gpu_rd_req,
  output logic              gpu_rd_rdy,
  output logic [DATA_W-1:0] gpu_rData,
  input  logic              ram_slot,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  output logic              ram_rd_ena,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy,
  output logic              overrun,
  output logic              timeout
);

  if (READ_LATENCY < 1 || READ_LATENCY > 4 || TIMEOUT < 1) begin : g_param_check
    $error("gpu_ram_host_port: READ_LATENCY must be 1..4 and TIMEOUT >= 1");
  end

  host_state_e       state_reg, state_next;
  logic              wr_valid_reg, rd_valid_reg;
  logic [ADDR_W-1:0] wr_addr_reg, rd_addr_reg;
  logic [DATA_W-1:0] wr_data_reg;
  logic              wr_issue, rd_issue, wr_clear, rd_clear;
  logic              wr_abort, rd_abort, rd_abort_pulse, rd_done;

  // Write has priority; only one read may be outstanding at a time.
  assign wr_issue = ram_slot && wr_valid_reg;
  assign rd_issue = ram_slot && rd_valid_reg && !wr_valid_reg && (state_reg != ST_RD_WAIT);
  assign wr_clear = wr_issue || wr_abort;
  assign rd_clear = rd_issue || rd_abort;
  assign busy     = wr_valid_reg || rd_valid_reg || (state_reg == ST_RD_WAIT);

`ifdef GPU_HOST_PORT_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] wr_cnt_reg, rd_cnt_reg;
  logic             wr_wait, rd_wait;

  // A read blocked behind an in-flight read is not waiting for a slot.
  assign wr_wait  = wr_valid_reg && !wr_issue;
  assign rd_wait  = rd_valid_reg && !rd_issue && (state_reg != ST_RD_WAIT);
  assign wr_abort = wr_wait && (wr_cnt_reg == CNT_W'(TIMEOUT - 1));
  assign rd_abort = rd_wait && (rd_cnt_reg == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge GPU_CLK or negedge reset) begin
    if (!reset) begin
      wr_cnt_reg     <= '0;
      rd_cnt_reg     <= '0;
      timeout        <= 1'b0;
      rd_abort_pulse <= 1'b0;
    end else begin
      wr_cnt_reg     <= (wr_wait && !wr_abort) ? wr_cnt_reg + CNT_W'(1) : '0;
      rd_cnt_reg     <= (rd_wait && !rd_abort) ? rd_cnt_reg + CNT_W'(1) : '0;
      timeout        <= wr_abort || rd_abort;
      rd_abort_pulse <= rd_abort;
    end
  end
`else
  assign wr_abort       = 1'b0;
  assign rd_abort       = 1'b0;
  assign rd_abort_pulse = 1'b0;
  assign timeout        = 1'b0;
`endif

  always_ff @(posedge GPU_CLK or negedge reset) begin
    if (!reset) begin
      state_reg    <= ST_IDLE;
      wr_valid_reg <= 1'b0;
      wr_addr_reg  <= '0;
      wr_data_reg  <= '0;
      rd_valid_reg <= 1'b0;
      rd_addr_reg  <= '0;
      overrun      <= 1'b0;
      ram_we       <= 1'b0;
      ram_rd_ena   <= 1'b0;
      ram_addr     <= '0;
      ram_wdata    <= '0;
    end else begin
      state_reg <= state_next;

      // A strobe landing on the clearing edge reloads the buffer.
      if (gpu_wr_ena && (!wr_valid_reg || wr_clear)) begin
        wr_valid_reg <= 1'b1;
        wr_addr_reg  <= gpu_addr;
        wr_data_reg  <= gpu_wdata;
      end else if (wr_clear) begin
        wr_valid_reg <= 1'b0;
      end

      if (gpu_rd_req && (!rd_valid_reg || rd_clear)) begin
        rd_valid_reg <= 1'b1;
        rd_addr_reg  <= gpu_addr;
      end else if (rd_clear) begin
        rd_valid_reg <= 1'b0;
      end

      overrun    <= (gpu_wr_ena && wr_valid_reg && !wr_clear) ||
                    (gpu_rd_req && rd_valid_reg && !rd_clear);
      ram_we     <= wr_issue;
      ram_rd_ena <= rd_issue;
      ram_addr   <= wr_issue ? wr_addr_reg : (rd_issue ? rd_addr_reg : '0);
      ram_wdata  <= wr_issue ? wr_data_reg : '0;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE, ST_PEND: begin
        if (rd_issue) begin
          state_next = ST_RD_WAIT;
        end else if (wr_valid_reg || rd_valid_reg) begin
          state_next = ST_PEND;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_RD_WAIT: begin
        if (rd_done) begin
          state_next = (wr_valid_reg || rd_valid_reg) ? ST_PEND : ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  gpu_rd_return_pipe #(
    .READ_LATENCY(READ_LATENCY)
  ) u_rd_return_pipe (
    .GPU_CLK   (GPU_CLK),
    .reset     (reset),
    .rd_launch (ram_rd_ena),
    .rd_abort  (rd_abort_pulse),
    .ram_rdata (ram_rdata),
    .rd_done   (rd_done),
    .gpu_rd_rdy(gpu_rd_rdy),
    .gpu_rData (gpu_rData)
  );

endmodule

// File: tb/tb_gpu_ram_host_port.sv
// Directed bench for gpu_ram_host_port with a small latency-2 RAM model.
module tb_gpu_ram_host_port;

  logic        GPU_CLK;
  logic        reset;
  logic [19:0] gpu_addr;
  logic [7:0]  gpu_wdata;
  logic        gpu_wr_ena;
  logic        gpu_rd_req;
  logic        gpu_rd_rdy;
  logic [7:0]  gpu_rData;
  logic        ram_slot;
  logic [19:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic        ram_we;
  logic        ram_rd_ena;
  logic [7:0]  ram_rdata;
  logic        busy;
  logic        overrun;
  logic        timeout;

  int n_total = 0;
  int n_pass  = 0;
  int rdy_total = 0;
  int ovr_total = 0;
  int to_total  = 0;
  int rdy0, ovr0;

  logic [7:0] ram_mem_data = 8'h00;
  logic [1:0] lat_sh = '0;

  gpu_ram_host_port #(
    .ADDR_W(20),
    .READ_LATENCY(2),
    .TIMEOUT(8)
  ) dut (
    .GPU_CLK   (GPU_CLK),
    .reset     (reset),
    .gpu_addr  (gpu_addr),
    .gpu_wdata (gpu_wdata),
    .gpu_wr_ena(gpu_wr_ena),
    .gpu_rd_req(gpu_rd_req),
    .gpu_rd_rdy(gpu_rd_rdy),
    .gpu_rData (gpu_rData),
    .ram_slot  (ram_slot),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_we    (ram_we),
    .ram_rd_ena(ram_rd_ena),
    .ram_rdata (ram_rdata),
    .busy      (busy),
    .overrun   (overrun),
    .timeout   (timeout)
  );

  initial GPU_CLK = 1'b0;
  always #5 GPU_CLK = ~GPU_CLK;

  // RAM model: data valid exactly two cycles after the ram_rd_ena cycle.
  always @(posedge GPU_CLK) lat_sh <= {lat_sh[0], ram_rd_ena};
  assign ram_rdata = lat_sh[1] ? ram_mem_data : 8'h00;

  always @(negedge GPU_CLK) begin
    if (gpu_rd_rdy) rdy_total <= rdy_total + 1;
    if (overrun)    ovr_total <= ovr_total + 1;
    if (timeout)    to_total  <= to_total + 1;
  end

  task automatic tick();
    @(posedge GPU_CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    reset = 1'b0; gpu_addr = '0; gpu_wdata = '0; gpu_wr_ena = 1'b0;
    gpu_rd_req = 1'b0; ram_slot = 1'b0;

    // Reset state
    repeat (3) tick();
    chk("rst_outputs", {gpu_rd_rdy, gpu_rData, ram_we, ram_rd_ena, busy, overrun, timeout}, 0);
    chk("rst_ram_addr", ram_addr, 0);
    tick(); reset = 1'b1;
    tick();
    chk("idle_busy", busy, 0);

    // Best-case read with slot held high
    tick();
    gpu_rd_req = 1'b1; gpu_addr = 20'h00123; ram_slot = 1'b1; ram_mem_data = 8'h5A;
    rdy0 = rdy_total;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 1) gpu_rd_req = 1'b0;
      chk($sformatf("rd_ena_T%0d", k), ram_rd_ena, (k == 2));
      chk($sformatf("rd_rdy_T%0d", k), gpu_rd_rdy, (k == 5));
      if (k == 1) chk("rd_busy_T1", busy, 1);
      if (k == 2) chk("rd_addr", ram_addr, 20'h00123);
      if (k >= 5) chk($sformatf("rd_data_T%0d", k), gpu_rData, 8'h5A);
    end
    ram_slot = 1'b0;
    tick();
    chk("rd_busy_after", busy, 0);
    chk("rd_rdy_count", rdy_total - rdy0, 1);

    // Write with slot withheld for 10 cycles
    tick();
    gpu_wr_ena = 1'b1; gpu_addr = 20'h7FFFF; gpu_wdata = 8'hC3; ram_slot = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 1) gpu_wr_ena = 1'b0;
      chk($sformatf("wr_wait_busy_%0d", k), busy, 1);
      chk($sformatf("wr_wait_we_%0d", k), ram_we, 0);
    end
    tick(); ram_slot = 1'b1;
    chk("wr_busy_slot", busy, 1);
    tick(); ram_slot = 1'b0;
    chk("wr_we", ram_we, 1);
    chk("wr_addr", ram_addr, 20'h7FFFF);
    chk("wr_data", ram_wdata, 8'hC3);
    tick();
    chk("wr_we_off", ram_we, 0);
    chk("wr_busy_off", busy, 0);

    // Simultaneous read and write strobes, two slot pulses
    tick();
    gpu_rd_req = 1'b1; gpu_wr_ena = 1'b1; gpu_addr = 20'h0ABCD; gpu_wdata = 8'h11;
    ram_mem_data = 8'h3C; ram_slot = 1'b0;
    tick(); gpu_rd_req = 1'b0; gpu_wr_ena = 1'b0; ram_slot = 1'b1;
    tick(); ram_slot = 1'b0;
    chk("sim_we_first", {ram_we, ram_rd_ena}, 2'b10);
    chk("sim_wdata", ram_wdata, 8'h11);
    tick(); ram_slot = 1'b1;
    chk("sim_gap", {ram_we, ram_rd_ena}, 2'b00);
    tick(); ram_slot = 1'b0;
    chk("sim_rd_second", {ram_we, ram_rd_ena}, 2'b01);
    chk("sim_rd_addr", ram_addr, 20'h0ABCD);
    tick(); tick(); tick();
    chk("sim_rdy", gpu_rd_rdy, 1);
    chk("sim_rdata", gpu_rData, 8'h3C);

    // Overrun on a second read while the first is still buffered
    tick();
    gpu_rd_req = 1'b1; gpu_addr = 20'h00AAA; ram_slot = 1'b0; ram_mem_data = 8'h77;
    rdy0 = rdy_total; ovr0 = ovr_total;
    tick(); gpu_addr = 20'h00BBB;
    chk("ovr_none_yet", overrun, 0);
    tick(); gpu_rd_req = 1'b0;
    chk("ovr_pulse", overrun, 1);
    tick(); ram_slot = 1'b1;
    chk("ovr_pulse_end", overrun, 0);
    tick(); ram_slot = 1'b0;
    chk("ovr_rd_ena", ram_rd_ena, 1);
    chk("ovr_first_addr", ram_addr, 20'h00AAA);
    repeat (6) tick();
    chk("ovr_rdy_count", rdy_total - rdy0, 1);
    chk("ovr_count", ovr_total - ovr0, 1);
    chk("ovr_rdata", gpu_rData, 8'h77);

    // Reset asserted in the cycle after ram_rd_ena
    tick();
    gpu_rd_req = 1'b1; gpu_addr = 20'h00555; ram_slot = 1'b1; ram_mem_data = 8'h99;
    rdy0 = rdy_total;
    tick(); gpu_rd_req = 1'b0;
    tick(); ram_slot = 1'b0;
    chk("mid_rd_ena", ram_rd_ena, 1);
    tick(); reset = 1'b0;
    #1;
    chk("mid_rst_outputs", {gpu_rd_rdy, gpu_rData, ram_we, ram_rd_ena, busy, overrun, timeout}, 0);
    chk("mid_rst_addr", ram_addr, 0);
    tick(); tick(); reset = 1'b1;
    repeat (6) tick();
    chk("mid_no_rdy", rdy_total - rdy0, 0);
    chk("mid_rdata_zero", gpu_rData, 8'h00);

    // Timeout behaviour
    tick();
    gpu_rd_req = 1'b1; gpu_addr = 20'h00321; ram_slot = 1'b0;
    rdy0 = rdy_total;
`ifdef GPU_HOST_PORT_TIMEOUT_EN
    for (int k = 1; k <= 11; k++) begin
      tick();
      if (k == 1) gpu_rd_req = 1'b0;
      chk($sformatf("to_pulse_T%0d", k), timeout, (k == 9));
      chk($sformatf("to_rdy_T%0d", k), gpu_rd_rdy, (k == 10));
      if (k == 10) chk("to_abort_data", gpu_rData, 8'hFF);
    end
    chk("to_rdy_count", rdy_total - rdy0, 1);
    chk("to_busy_after", busy, 0);
`else
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 1) gpu_rd_req = 1'b0;
    end
    chk("nto_timeout_count", to_total, 0);
    chk("nto_no_rdy", rdy_total - rdy0, 0);
    chk("nto_still_busy", busy, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
